// File: rtl/pll_reconfig_pkg.sv
// Shared types, DRP register map and divider encoding for the PLL reconfiguration controller.
package pll_reconfig_pkg;

  localparam int unsigned DIV_W   = 7;
  localparam int unsigned FIELD_W = 6;
  localparam int unsigned DRP_AW  = 7;
  localparam int unsigned DRP_DW  = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PLL_RST,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_WR_WAIT,
    ST_RELEASE,
    ST_WAIT_LOCK,
    ST_STABLE
  } ctrl_state_e;

  // Divider registers of CLKOUT0 and CLKOUT1, in programming order.
  localparam logic [DRP_AW-1:0] ADDR_CLK0_REG1 = 7'h08;
  localparam logic [DRP_AW-1:0] ADDR_CLK0_REG2 = 7'h09;
  localparam logic [DRP_AW-1:0] ADDR_CLK1_REG1 = 7'h0A;
  localparam logic [DRP_AW-1:0] ADDR_CLK1_REG2 = 7'h0B;

  // Bits preserved from the read value during read-modify-write.
  localparam logic [DRP_DW-1:0] KEEP_REG1 = 16'h1000;
  localparam logic [DRP_DW-1:0] KEEP_REG2 = 16'hFC00;

  // New-field contents of one output's ClkReg1/ClkReg2 (kept bits are zero here).
  typedef struct packed {
    logic [DRP_DW-1:0] reg1;
    logic [DRP_DW-1:0] reg2;
  } clk_regs_t;

  // Split a divide into high/low counts plus edge/no_count; 0 behaves as 1.
  function automatic clk_regs_t div_to_regs(input logic [DIV_W-1:0] div);
    clk_regs_t          r;
    logic [DIV_W-1:0]   d;
    logic [FIELD_W-1:0] hi;
    logic [FIELD_W-1:0] lo;
    logic               edge_bit;
    logic               no_count;
    d = (div == '0) ? DIV_W'(1) : div;
    if (d == DIV_W'(1)) begin
      hi       = FIELD_W'(1);
      lo       = FIELD_W'(1);
      edge_bit = 1'b0;
      no_count = 1'b1;
    end else begin
      // A low count of 64 wraps to 0, which is the hardware encoding for 64.
      hi       = FIELD_W'(d >> 1);
      lo       = FIELD_W'(d - DIV_W'(hi));
      edge_bit = d[0];
      no_count = 1'b0;
    end
    r.reg1 = {3'b000, 1'b0, hi, lo};
    r.reg2 = {6'b000000, 2'b00, edge_bit, no_count, 6'b000000};
    return r;
  endfunction

  // DRP address of programming step idx.
  function automatic logic [DRP_AW-1:0] step_addr(input logic [1:0] idx);
    logic [DRP_AW-1:0] a;
    case (idx)
      2'd0:    a = ADDR_CLK0_REG1;
      2'd1:    a = ADDR_CLK0_REG2;
      2'd2:    a = ADDR_CLK1_REG1;
      default: a = ADDR_CLK1_REG2;
    endcase
    return a;
  endfunction

  // Merge read data with the new divider fields for programming step idx.
  function automatic logic [DRP_DW-1:0] merge_wdata(input logic [1:0]        idx,
                                                     input logic [DRP_DW-1:0] rdata,
                                                     input logic [DIV_W-1:0]  div);
    clk_regs_t r;
    r = div_to_regs(div);
    return idx[0] ? ((rdata & KEEP_REG2) | r.reg2) : ((rdata & KEEP_REG1) | r.reg1);
  endfunction

endpackage

// File: rtl/pll_lock_qual.sv
// Synchronises PLL LOCKED and qualifies it: stable-run counter, lock timeout, lock-loss flag.
module pll_lock_qual #(
  parameter int unsigned LockStableCycles = 1024,
  parameter int unsigned LockTimeout      = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic locked,
  input  logic run,
  input  logic wait_en,
  output logic locked_sync,
  output logic stable_c,
  output logic timeout_c,
  output logic lost_c
);

  localparam int unsigned SCNT_W = $clog2(LockStableCycles + 1);
  localparam int unsigned TCNT_W = $clog2(LockTimeout + 1);

  logic              sync_meta;
  logic [SCNT_W-1:0] stable_cnt;
  logic [TCNT_W-1:0] timeout_cnt;

  // Two-flop synchroniser for the asynchronous LOCKED input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta   <= 1'b0;
      locked_sync <= 1'b0;
    end else begin
      sync_meta   <= locked;
      locked_sync <= sync_meta;
    end
  end

  // Consecutive locked cycles while qualifying; any drop restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_cnt <= '0;
    end else if (!run || !locked_sync) begin
      stable_cnt <= '0;
    end else if (stable_cnt != SCNT_W'(LockStableCycles)) begin
      stable_cnt <= stable_cnt + SCNT_W'(1);
    end
  end

  // Cycles spent waiting for lock; saturates once the timeout is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_cnt <= '0;
    end else if (!wait_en) begin
      timeout_cnt <= '0;
    end else if (timeout_cnt != TCNT_W'(LockTimeout)) begin
      timeout_cnt <= timeout_cnt + TCNT_W'(1);
    end
  end

  assign stable_c  = (stable_cnt == SCNT_W'(LockStableCycles));
  assign timeout_c = (timeout_cnt == TCNT_W'(LockTimeout));
  assign lost_c    = !locked_sync;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// DRP-based run-time divider reconfiguration of the system PLL and owner of the system reset.
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned LockStableCycles = 1024,
  parameter int unsigned DrdyTimeout      = 64,
  parameter int unsigned LockTimeout      = 65536,
  parameter int unsigned PllRstCycles     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_req_i,
  input  logic [DIV_W-1:0]  cfg_div0_i,
  input  logic [DIV_W-1:0]  cfg_div1_i,
  output logic              cfg_ack_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [DRP_AW-1:0] drp_addr_o,
  output logic              drp_en_o,
  output logic              drp_we_o,
  output logic [DRP_DW-1:0] drp_di_o,
  input  logic [DRP_DW-1:0] drp_do_i,
  input  logic              drp_rdy_i,
  input  logic              locked_i,
  output logic              pll_rst_o,
  output logic              sys_rst_o
);

  localparam int unsigned TMR_MAX = (DrdyTimeout > PllRstCycles) ? DrdyTimeout : PllRstCycles;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  ctrl_state_e      state;
  logic [1:0]       idx;
  logic [TMR_W-1:0] tmr;
  logic [DIV_W-1:0] div0_q;
  logic [DIV_W-1:0] div1_q;
  logic             req_active;
  logic [DIV_W-1:0] cur_div_c;
  logic             lock_run_c;
  logic             lock_wait_c;
  logic             locked_sync;
  logic             stable_c;
  logic             timeout_c;
  logic             lost_c;

  assign lock_run_c  = (state == ST_WAIT_LOCK) || (state == ST_STABLE);
  assign lock_wait_c = (state == ST_WAIT_LOCK);
  assign cur_div_c   = idx[1] ? div1_q : div0_q;

  pll_lock_qual #(
    .LockStableCycles(LockStableCycles),
    .LockTimeout     (LockTimeout)
  ) u_lock_qual (
    .clk        (clk_i),
    .rst        (rst_i),
    .locked     (locked_i),
    .run        (lock_run_c),
    .wait_en    (lock_wait_c),
    .locked_sync(locked_sync),
    .stable_c   (stable_c),
    .timeout_c  (timeout_c),
    .lost_c     (lost_c)
  );

  // Sequencer: PLL reset, four read-modify-write DRP steps, release, lock qualification.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_WAIT_LOCK;
      idx        <= '0;
      tmr        <= '0;
      div0_q     <= '0;
      div1_q     <= '0;
      req_active <= 1'b0;
      cfg_ack_o  <= 1'b0;
      busy_o     <= 1'b1;
      err_o      <= 1'b0;
      drp_addr_o <= '0;
      drp_en_o   <= 1'b0;
      drp_we_o   <= 1'b0;
      drp_di_o   <= '0;
      pll_rst_o  <= 1'b0;
      sys_rst_o  <= 1'b1;
    end else begin
      drp_en_o  <= 1'b0;
      drp_we_o  <= 1'b0;
      cfg_ack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_req_i) begin
            div0_q     <= cfg_div0_i;
            div1_q     <= cfg_div1_i;
            err_o      <= 1'b0;
            sys_rst_o  <= 1'b1;
            pll_rst_o  <= 1'b1;
            idx        <= '0;
            tmr        <= '0;
            req_active <= 1'b1;
            busy_o     <= 1'b1;
            state      <= ST_PLL_RST;
          end else if (lost_c) begin
            sys_rst_o <= 1'b1;
            busy_o    <= 1'b1;
            state     <= ST_WAIT_LOCK;
          end
        end
        ST_PLL_RST: begin
          if (tmr == TMR_W'(PllRstCycles - 1)) begin
            drp_en_o   <= 1'b1;
            drp_addr_o <= step_addr(idx);
            state      <= ST_RD;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        ST_RD: begin
          tmr   <= '0;
          state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (drp_rdy_i) begin
            drp_en_o <= 1'b1;
            drp_we_o <= 1'b1;
            drp_di_o <= merge_wdata(idx, drp_do_i, cur_div_c);
            state    <= ST_WR;
          end else if (tmr == TMR_W'(DrdyTimeout - 1)) begin
            err_o <= 1'b1;
            state <= ST_RELEASE;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        ST_WR: begin
          tmr   <= '0;
          state <= ST_WR_WAIT;
        end
        ST_WR_WAIT: begin
          if (drp_rdy_i) begin
            if (idx == 2'd3) begin
              state <= ST_RELEASE;
            end else begin
              idx        <= idx + 2'd1;
              drp_en_o   <= 1'b1;
              drp_addr_o <= step_addr(idx + 2'd1);
              state      <= ST_RD;
            end
          end else if (tmr == TMR_W'(DrdyTimeout - 1)) begin
            err_o <= 1'b1;
            state <= ST_RELEASE;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        ST_RELEASE: begin
          pll_rst_o <= 1'b0;
          state     <= ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (timeout_c) begin
            err_o <= 1'b1;
          end
          if (locked_sync) begin
            state <= ST_STABLE;
          end
        end
        ST_STABLE: begin
          if (lost_c) begin
            state <= ST_WAIT_LOCK;
          end else if (stable_c) begin
            sys_rst_o  <= 1'b0;
            cfg_ack_o  <= req_active;
            req_active <= 1'b0;
            busy_o     <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_WAIT_LOCK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with a behavioural DRP port and PLL lock model.
module tb_pll_reconfig_ctrl;

  localparam int unsigned LOCK_STABLE = 1024;
  localparam int unsigned DRDY_TO     = 64;
  localparam int unsigned LOCK_TO     = 65536;
  localparam int unsigned PLL_RST_CYC = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_req_i = 1'b0;
  logic [6:0]  cfg_div0_i = '0;
  logic [6:0]  cfg_div1_i = '0;
  logic        cfg_ack_o;
  logic        busy_o;
  logic        err_o;
  logic [6:0]  drp_addr_o;
  logic        drp_en_o;
  logic        drp_we_o;
  logic [15:0] drp_di_o;
  logic [15:0] drp_do_i = '0;
  logic        drp_rdy_i = 1'b0;
  logic        locked_i = 1'b0;
  logic        pll_rst_o;
  logic        sys_rst_o;

  int checks = 0;
  int failures = 0;

  // Model state
  logic        lock_en = 1'b0;
  logic        fail_rd2 = 1'b0;
  logic        pend = 1'b0;
  int          rd_cnt = 0;
  int          en_cnt = 0;
  int          ack_cnt = 0;
  int          bad_wr = 0;
  logic [22:0] wr_log[$];

  always #5 clk_i = ~clk_i;

  pll_reconfig_ctrl #(
    .LockStableCycles(LOCK_STABLE),
    .DrdyTimeout     (DRDY_TO),
    .LockTimeout     (LOCK_TO),
    .PllRstCycles    (PLL_RST_CYC)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cfg_req_i (cfg_req_i),
    .cfg_div0_i(cfg_div0_i),
    .cfg_div1_i(cfg_div1_i),
    .cfg_ack_o (cfg_ack_o),
    .busy_o    (busy_o),
    .err_o     (err_o),
    .drp_addr_o(drp_addr_o),
    .drp_en_o  (drp_en_o),
    .drp_we_o  (drp_we_o),
    .drp_di_o  (drp_di_o),
    .drp_do_i  (drp_do_i),
    .drp_rdy_i (drp_rdy_i),
    .locked_i  (locked_i),
    .pll_rst_o (pll_rst_o),
    .sys_rst_o (sys_rst_o)
  );

  // DRP responder (reads return 0xFFFF one cycle after the access), write log, PLL lock model.
  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      drp_rdy_i = 1'b0;
      if (pend) begin
        pend      = 1'b0;
        drp_rdy_i = 1'b1;
        drp_do_i  = 16'hFFFF;
      end
      if (drp_en_o) begin
        en_cnt++;
        if (drp_we_o) begin
          wr_log.push_back({drp_addr_o, drp_di_o});
          if (!pll_rst_o) bad_wr++;
          pend = 1'b1;
        end else begin
          rd_cnt++;
          if (!(fail_rd2 && rd_cnt == 2)) pend = 1'b1;
        end
      end
      if (cfg_ack_o) ack_cnt++;
      locked_i = lock_en && !pll_rst_o;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_pll_rst"}, 32'(pll_rst_o), 32'd0);
    check_eq({pfx, "_sys_rst"}, 32'(sys_rst_o), 32'd1);
    check_eq({pfx, "_ack"}, 32'(cfg_ack_o), 32'd0);
    check_eq({pfx, "_busy"}, 32'(busy_o), 32'd1);
    check_eq({pfx, "_err"}, 32'(err_o), 32'd0);
    check_eq({pfx, "_drp"}, 32'({drp_addr_o, drp_en_o, drp_we_o, drp_di_o}), 32'd0);
  endtask

  // Enable lock at a negedge and count edges after LOCKED is first sampled until sys_rst_o drops.
  task automatic measure_release(output int n);
    lock_en = 1'b1;
    n = -1;
    @(posedge clk_i);
    @(posedge clk_i);
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (!sys_rst_o) begin
        n = i;
        break;
      end
    end
  endtask

  // Raise a request at a negedge, hold it until ack (bounded), then drop it.
  task automatic do_request(input logic [6:0] d0, input logic [6:0] d1, output logic acked,
                            output logic err_start, output logic err_ack, output logic srst_ack);
    wr_log.delete();
    rd_cnt     = 0;
    cfg_div0_i = d0;
    cfg_div1_i = d1;
    cfg_req_i  = 1'b1;
    acked      = 1'b0;
    err_ack    = 1'b0;
    srst_ack   = 1'b1;
    @(negedge clk_i);
    err_start = err_o;
    for (int i = 0; i < 4000; i++) begin
      if (cfg_ack_o) begin
        acked    = 1'b1;
        err_ack  = err_o;
        srst_ack = sys_rst_o;
        break;
      end
      @(negedge clk_i);
    end
    cfg_req_i = 1'b0;
  endtask

  logic [6:0]  tbl_d0[3];
  logic [6:0]  tbl_d1[3];
  logic [15:0] tbl_wr[3][4];
  logic [6:0]  tbl_addr[4];

  initial begin
    int          n;
    int          ack0;
    int          en0;
    logic        acked;
    logic        err_s;
    logic        err_a;
    logic        srst_a;
    logic        found;
    logic [22:0] got;

    // 17: high 8 / low 9, odd; 4: 2/2; 1 and 0: no_count; 127: low 64 encodes as 0; 2: 1/1.
    tbl_d0   = '{7'd17, 7'd1, 7'd127};
    tbl_d1   = '{7'd4, 7'd0, 7'd2};
    tbl_wr   = '{'{16'h1209, 16'hFC80, 16'h1082, 16'hFC00},
                 '{16'h1041, 16'hFC40, 16'h1041, 16'hFC40},
                 '{16'h1FC0, 16'hFC80, 16'h1041, 16'hFC00}};
    tbl_addr = '{7'h08, 7'h09, 7'h0A, 7'h0B};

    // Reset values
    repeat (3) @(negedge clk_i);
    check_reset_outputs("por");

    // Power-up lock qualification
    rst_i = 1'b0;
    repeat (98) @(negedge clk_i);
    check_eq("pu_sys_rst_held", 32'(sys_rst_o), 32'd1);
    measure_release(n);
    check_eq("pu_release_delay", 32'(n), 32'(LOCK_STABLE + 2));
    check_eq("pu_no_ack", 32'(ack_cnt), 32'd0);
    check_eq("pu_busy", 32'(busy_o), 32'd0);

    // Reconfiguration vectors
    for (int t = 0; t < 3; t++) begin
      ack0 = ack_cnt;
      do_request(tbl_d0[t], tbl_d1[t], acked, err_s, err_a, srst_a);
      check_eq($sformatf("req%0d_ack", t), 32'(acked), 32'd1);
      check_eq($sformatf("req%0d_sys_rst_at_ack", t), 32'(srst_a), 32'd0);
      check_eq($sformatf("req%0d_err", t), 32'(err_a), 32'd0);
      check_eq($sformatf("req%0d_nwr", t), 32'(wr_log.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
        got = (i < wr_log.size()) ? wr_log[i] : '1;
        check_eq($sformatf("req%0d_wr%0d", t, i), 32'(got), 32'({tbl_addr[i], tbl_wr[t][i]}));
      end
      @(negedge clk_i);
      check_eq($sformatf("req%0d_ack_pulses", t), 32'(ack_cnt - ack0), 32'd1);
      check_eq($sformatf("req%0d_pll_rst_off", t), 32'(pll_rst_o), 32'd0);
    end
    check_eq("wr_under_pll_rst", 32'(bad_wr), 32'd0);

    // DRP ready never arrives on the second read
    fail_rd2 = 1'b1;
    do_request(7'd5, 7'd5, acked, err_s, err_a, srst_a);
    fail_rd2 = 1'b0;
    check_eq("drdy_to_ack", 32'(acked), 32'd1);
    check_eq("drdy_to_err", 32'(err_a), 32'd1);
    check_eq("drdy_to_nwr", 32'(wr_log.size()), 32'd1);
    check_eq("drdy_to_pll_rel", 32'(pll_rst_o), 32'd0);
    do_request(7'd3, 7'd3, acked, err_s, err_a, srst_a);
    check_eq("err_clear_on_req", 32'(err_s), 32'd0);
    check_eq("err_clear_ack", 32'(acked), 32'd1);
    check_eq("err_clear_final", 32'(err_a), 32'd0);

    // Lock loss in IDLE reasserts the system reset without an ack
    @(negedge clk_i);
    ack0    = ack_cnt;
    lock_en = 1'b0;
    repeat (5) @(negedge clk_i);
    check_eq("idle_loss_sys_rst", 32'(sys_rst_o), 32'd1);
    check_eq("idle_loss_busy", 32'(busy_o), 32'd1);
    measure_release(n);
    check_eq("idle_loss_release", 32'(n), 32'(LOCK_STABLE + 2));

    // Glitch mid-STABLE restarts the stable count
    lock_en = 1'b0;
    repeat (5) @(negedge clk_i);
    lock_en = 1'b1;
    repeat (500) @(negedge clk_i);
    check_eq("stable_mid_sys_rst", 32'(sys_rst_o), 32'd1);
    lock_en = 1'b0;
    repeat (2) @(negedge clk_i);
    measure_release(n);
    check_eq("stable_glitch_release", 32'(n), 32'(LOCK_STABLE + 2));
    check_eq("glitch_no_ack", 32'(ack_cnt - ack0), 32'd0);

    // Asynchronous reset during WR_WAIT
    cfg_div0_i = 7'd17;
    cfg_div1_i = 7'd4;
    rd_cnt     = 0;
    cfg_req_i  = 1'b1;
    found      = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (drp_we_o) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("mid_rst_reached_wr", 32'(found), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_reset_outputs("mid");
    cfg_req_i = 1'b0;
    ack0      = ack_cnt;
    @(negedge clk_i);
    en0   = en_cnt;
    rst_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i);
      if (!sys_rst_o) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("mid_rst_relock", 32'(found), 32'd1);
    check_eq("mid_rst_no_drp", 32'(en_cnt - en0), 32'd0);
    check_eq("mid_rst_no_ack", 32'(ack_cnt - ack0), 32'd0);
    check_eq("mid_rst_busy", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
